// File: rtl/posit_extract_pipe.sv
// rtl/posit_extract_pipe.sv - three-stage pipelined posit field decoder with NaR/zero event counters
module posit_extract_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int FBITS = NBITS - 3 - ES,
  parameter int SBITS = $clog2(NBITS) + ES + 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in_posit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_sgn,
  output logic [SBITS-1:0] out_scale,
  output logic [FBITS-1:0] out_frac,
  output logic             out_inf,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] nar_count,
  output logic [CNT_W-1:0] zero_count
);

  // Regime run length is 1..NBITS-1, which always fits in clog2(NBITS) bits.
  localparam int MW = $clog2(NBITS);

  logic stall;
  logic xfer_out;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sgn_q, s1_sgn_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_inf_q, s1_inf_d;
  logic [NBITS-1:0] s1_u_q, s1_u_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_sgn_q, s2_sgn_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_inf_q, s2_inf_d;
  logic             s2_r0_q, s2_r0_d;
  logic [MW-1:0]    s2_m_q, s2_m_d;
  logic [NBITS-2:0] s2_rest_q, s2_rest_d;

  logic             out_valid_q, out_valid_d;
  logic             out_sgn_q, out_sgn_d;
  logic [SBITS-1:0] out_scale_q, out_scale_d;
  logic [FBITS-1:0] out_frac_q, out_frac_d;
  logic             out_inf_q, out_inf_d;
  logic             out_zero_q, out_zero_d;

  logic [CNT_W-1:0] nar_cnt_q, nar_cnt_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  logic             run_done;
  logic [MW-1:0]    run_m;
  logic [MW:0]      strip_sh;
  logic [NBITS-2:0] rest_c;

  logic [SBITS-1:0] m_ext;
  logic [SBITS-1:0] k_c;
  logic [NBITS-1:0] e_wide;
  logic [SBITS-1:0] scale_c;
  logic [FBITS-1:0] frac_c;

  // The whole pipe freezes as one unit when the sink refuses a valid output.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = reset | ~stall;
  assign xfer_out = out_valid_q & out_ready;

  // Stage 1: split sign, take two's-complement magnitude, flag the two specials.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sgn_d   = s1_sgn_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_u_d     = s1_u_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      s1_sgn_d   = in_posit[NBITS-1];
      s1_zero_d  = (in_posit == '0);
      s1_inf_d   = (in_posit == {1'b1, {(NBITS-1){1'b0}}});
      s1_u_d     = in_posit[NBITS-1] ? -in_posit : in_posit;
    end
  end

  // Regime run count from the bit under the sign, then shift out regime and terminator.
  always_comb begin
    run_done = 1'b0;
    run_m    = '0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!run_done) begin
        if (s1_u_q[i] == s1_u_q[NBITS-2]) begin
          run_m = run_m + MW'(1);
        end else begin
          run_done = 1'b1;
        end
      end
    end
    // Extra bit keeps m+1 from wrapping when the run fills the whole body.
    strip_sh = {1'b0, run_m} + (MW+1)'(1);
    rest_c   = s1_u_q[NBITS-2:0] << strip_sh;
  end

  // Stage 2: register the run length and the MSB-aligned exponent/fraction bits.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sgn_d   = s2_sgn_q;
    s2_zero_d  = s2_zero_q;
    s2_inf_d   = s2_inf_q;
    s2_r0_d    = s2_r0_q;
    s2_m_d     = s2_m_q;
    s2_rest_d  = s2_rest_q;
    if (!stall) begin
      s2_valid_d = s1_valid_q;
      s2_sgn_d   = s1_sgn_q;
      s2_zero_d  = s1_zero_q;
      s2_inf_d   = s1_inf_q;
      s2_r0_d    = s1_u_q[NBITS-2];
      s2_m_d     = run_m;
      s2_rest_d  = rest_c;
    end
  end

  // Scale assembly: k from run polarity, exponent from the top ES bits left after stripping.
  always_comb begin
    m_ext   = SBITS'(s2_m_q);
    k_c     = s2_r0_q ? (m_ext - SBITS'(1)) : (~m_ext + SBITS'(1));
    e_wide  = {1'b0, s2_rest_q} >> (NBITS - 1 - ES);
    scale_c = (k_c << ES) + SBITS'(e_wide);
    frac_c  = s2_rest_q[NBITS-2-ES -: FBITS];
  end

  // Stage 3: output register; specials force sign, scale and fraction to zero.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sgn_d   = out_sgn_q;
    out_scale_d = out_scale_q;
    out_frac_d  = out_frac_q;
    out_inf_d   = out_inf_q;
    out_zero_d  = out_zero_q;
    if (!stall) begin
      out_valid_d = s2_valid_q;
      out_inf_d   = s2_inf_q;
      out_zero_d  = s2_zero_q;
      if (s2_zero_q || s2_inf_q) begin
        out_sgn_d   = 1'b0;
        out_scale_d = '0;
        out_frac_d  = '0;
      end else begin
        out_sgn_d   = s2_sgn_q;
        out_scale_d = scale_c;
        out_frac_d  = frac_c;
      end
    end
  end

  // Saturating event counters; a clear wins over a same-cycle increment.
  always_comb begin
    nar_cnt_d  = nar_cnt_q;
    zero_cnt_d = zero_cnt_q;
    if (cnt_clear) begin
      nar_cnt_d  = '0;
      zero_cnt_d = '0;
    end else begin
      if (xfer_out && out_inf_q && !(&nar_cnt_q)) begin
        nar_cnt_d = nar_cnt_q + CNT_W'(1);
      end
      if (xfer_out && out_zero_q && !(&zero_cnt_q)) begin
        zero_cnt_d = zero_cnt_q + CNT_W'(1);
      end
    end
  end

  // All state registers; reset empties the pipe and clears outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sgn_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_u_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_sgn_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_r0_q     <= 1'b0;
      s2_m_q      <= '0;
      s2_rest_q   <= '0;
      out_valid_q <= 1'b0;
      out_sgn_q   <= 1'b0;
      out_scale_q <= '0;
      out_frac_q  <= '0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      nar_cnt_q   <= '0;
      zero_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sgn_q    <= s1_sgn_d;
      s1_zero_q   <= s1_zero_d;
      s1_inf_q    <= s1_inf_d;
      s1_u_q      <= s1_u_d;
      s2_valid_q  <= s2_valid_d;
      s2_sgn_q    <= s2_sgn_d;
      s2_zero_q   <= s2_zero_d;
      s2_inf_q    <= s2_inf_d;
      s2_r0_q     <= s2_r0_d;
      s2_m_q      <= s2_m_d;
      s2_rest_q   <= s2_rest_d;
      out_valid_q <= out_valid_d;
      out_sgn_q   <= out_sgn_d;
      out_scale_q <= out_scale_d;
      out_frac_q  <= out_frac_d;
      out_inf_q   <= out_inf_d;
      out_zero_q  <= out_zero_d;
      nar_cnt_q   <= nar_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sgn    = out_sgn_q;
  assign out_scale  = out_scale_q;
  assign out_frac   = out_frac_q;
  assign out_inf    = out_inf_q;
  assign out_zero   = out_zero_q;
  assign nar_count  = nar_cnt_q;
  assign zero_count = zero_cnt_q;

endmodule
